multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Main sequencing controller for the multi-cycle variant of the RV32I core. One shared memory serves instructions and data, and one ALU serves PC increment, address, branch and arithmetic.
- Walks each instruction through FETCH/DECODE/EXECUTE/WRITEBACK states and drives every datapath enable and mux select each cycle.
- Stretches memory-access states with a `mem_ready` handshake so the core tolerates slow memory.

Parameters:
- `RESET_STATE`, 4'd0 (FETCH), state entered on reset.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `op` in 7: instruction opcode from IR.
- `funct3` in 3: instruction funct3.
- `funct7b5` in 1: instruction bit 30.
- `Zero` in 1: ALU result == 0.
- `mem_ready` in 1: memory access completes this cycle.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select (0=PC, 1=ALUOut).
- `MemWrite` out 1: memory write enable.
- `IRWrite` out 1: IR/OldPC load enable.
- `ResultSrc` out 2: result select (00=ALUOut, 01=Data, 10=ALUResult).
- `ALUSrcA` out 2: ALU A select (00=PC, 01=OldPC, 10=rs1).
- `ALUSrcB` out 2: ALU B select (00=rs2, 01=imm, 10=const 4).
- `ALUControl` out 3: ALU op (000 add, 001 sub, 010 and, 011 or, 101 slt).
- `ImmSrc` out 2: immediate format (00 I, 01 S, 10 B, 11 J).
- `RegWrite` out 1: register-file write enable.
- `halted` out 1: core stopped on illegal instruction (optional feature).
- `state_o` out 4: current state, for debug/verification.

Behaviour:
- Clock/reset: Moore FSM, 4-bit state register. `reset` high asynchronously forces FETCH. Reset mid-instruction abandons the instruction; no further enables fire.
- Outputs in reset: all enables 0, all selects 00, `ALUControl` 000, `halted` 0, `state_o` = FETCH.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- `ImmSrc`: combinational from `op` only (lw/I→00, sw→01, beq→10, jal→11, else 00).
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10. IRWrite=PCWrite=1 only in the cycle `mem_ready`=1. Stays in FETCH while `mem_ready`=0, otherwise goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target). Next state by opcode:
  - lw/sw → MEMADR
  - R → EXECUTER
  - I-ALU → EXECUTEI
  - beq → BEQ
  - jal → JAL
  - anything else → FETCH (silent NOP)
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next: lw→MEMREAD, sw→MEMWRITE.
- MEMREAD: AdrSrc=1. Holds while `mem_ready`=0, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then → FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held every cycle until `mem_ready`=1, then → FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, then → ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, then → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then → FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite=`Zero`. Then → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then → ALUWB (rd=PC+4).
- ALU decode when ALUOp is 10 (EXECUTER/EXECUTEI), by funct3:
  - 000: add; sub only when R-type and funct7b5=1. I-type funct3=000 is always add.
  - 010 → slt; 110 → or; 111 → and.
  - Other funct3 → add.
- Output cleanliness: outputs are purely state-decoded (plus `Zero`/`mem_ready` gating), registered-state Moore. No enable is asserted outside its listed states.
- Latency with `mem_ready` tied high:
  - lw 5 cycles
  - sw 4 cycles
  - R/I 4 cycles
  - beq 3 cycles
  - jal 4 cycles

Optional Feature:
- Macro: `CTRL_ILLEGAL_HALT_EN`.
- Defined: an unknown opcode in DECODE → HALT state. HALT drives all enables 0, `halted`=1, and is left only by `reset`.
- Undefined: unknown opcode → FETCH, and `halted` is tied 0.

Decomposition:
- Shared package `riscv_ctrl_pkg` holds:
  - state encodings (FETCH..JAL, HALT)
  - opcode constants
  - ALUControl codes
  - ImmSrc/ResultSrc/ALUSrc select codes
- One natural sub-module, `alu_decoder`: combinational (ALUOp, funct3, op[5], funct7b5) → ALUControl. The FSM emits the 2-bit ALUOp (00 add, 01 sub, 10 funct-decoded).

Test Plan:
- Reset/hold: `reset`=1 mid-MEMREAD, `mem_ready`=0 → `state_o`=FETCH immediately (async); all enables 0 while reset is high.
- lw, `mem_ready`=1: op=0000011 → states FETCH,DECODE,MEMADR,MEMREAD,MEMWB. RegWrite=1 and ResultSrc=01 only in cycle 5.
- sw with memory stall: op=0100011, `mem_ready` low 3 cycles in MEMWRITE → MemWrite=1 for 4 consecutive cycles, then FETCH.
- beq both outcomes: op=1100011 with Zero=1 → PCWrite=1 in the BEQ cycle, ALUControl=001. With Zero=0 → PCWrite=0.
- R-type sub vs I-type addi: funct3=000, funct7b5=1 → ALUControl=001 for op=0110011 and 000 for op=0010011. slt funct3=010 → 101.
- Illegal opcode 0000000: with `CTRL_ILLEGAL_HALT_EN` → `halted`=1 and remains so for 100 cycles. Without the macro → FETCH on the next cycle and `halted`=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: FSM state
// encodings, opcode constants, ALU operation codes and datapath select codes.
// Used by multicycle_control_fsm and alu_decoder.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10,
        StHalt     = 4'd11
    } state_e;

    localparam logic [6:0] OpLw  = 7'b0000011;
    localparam logic [6:0] OpSw  = 7'b0100011;
    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpBeq = 7'b1100011;
    localparam logic [6:0] OpJal = 7'b1101111;

    // ALUControl codes
    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    // ALUOp emitted by the FSM towards the ALU decoder
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    // Immediate format depends on the opcode alone.
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OpSw:    imm_src = ImmS;
            OpBeq:   imm_src = ImmB;
            OpJal:   imm_src = ImmJ;
            default: imm_src = ImmI;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder.
// Ports:
//   alu_op_i      - 00 add, 01 sub, 10 decode from funct fields
//   funct3_i      - instruction funct3
//   op_b5_i       - opcode bit 5 (1 = R-type, 0 = I-type ALU)
//   funct7b5_i    - instruction bit 30
//   alu_control_o - ALU operation code
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op_b5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = AluAdd;
        case (alu_op_i)
            AluOpSub: alu_control_o = AluSub;
            AluOpFunct: begin
                case (funct3_i)
                    // Bit 30 is part of the immediate for I-type, so only R-type may subtract.
                    3'b000:  alu_control_o = (op_b5_i && funct7b5_i) ? AluSub : AluAdd;
                    3'b010:  alu_control_o = AluSlt;
                    3'b110:  alu_control_o = AluOr;
                    3'b111:  alu_control_o = AluAnd;
                    default: alu_control_o = AluAdd;
                endcase
            end
            default: alu_control_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main sequencing controller of the multi-cycle RV32I core. A Moore FSM walks
// each instruction through fetch/decode/execute/writeback and drives every
// datapath enable and mux select; memory states stretch on mem_ready.
// Ports: clk, reset (async, active-high); op/funct3/funct7b5 from IR; Zero
// from ALU; mem_ready from memory; PCWrite, AdrSrc, MemWrite, IRWrite,
// ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite datapath
// controls; halted; state_o debug state.
// Optional: define CTRL_ILLEGAL_HALT_EN to halt on unknown opcodes.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       halted,
    output logic [3:0] state_o
);

    state_e     state_q, state_d;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] alu_control;
`ifdef CTRL_ILLEGAL_HALT_EN
    logic       halt_flag;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= state_e'(RESET_STATE);
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = ResAluOut;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBRs2;
        alu_op     = AluOpAdd;
`ifdef CTRL_ILLEGAL_HALT_EN
        halt_flag  = 1'b0;
`endif
        case (state_q)
            StFetch: begin
                alu_src_b  = SrcBFour;
                result_src = ResAluResult;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // Branch target computed speculatively from OldPC + imm.
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpR:        state_d = StExecuteR;
                    OpI:        state_d = StExecuteI;
                    OpBeq:      state_d = StBeq;
                    OpJal:      state_d = StJal;
`ifdef CTRL_ILLEGAL_HALT_EN
                    default:    state_d = StHalt;
`else
                    default:    state_d = StFetch;
`endif
                endcase
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                if (op == OpLw)      state_d = StMemRead;
                else if (op == OpSw) state_d = StMemWrite;
                else                 state_d = StFetch;
            end
            StMemRead: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = ResData;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = StFetch;
            end
            StExecuteR: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBRs2;
                alu_op    = AluOpFunct;
                state_d   = StAluWb;
            end
            StExecuteI: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_op    = AluOpFunct;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StBeq: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBRs2;
                alu_op    = AluOpSub;
                pc_write  = Zero;
                state_d   = StFetch;
            end
            StJal: begin
                // PC <= branch target from DECODE; ALU forms OldPC + 4 for rd.
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBFour;
                pc_write  = 1'b1;
                state_d   = StAluWb;
            end
`ifdef CTRL_ILLEGAL_HALT_EN
            StHalt: begin
                halt_flag = 1'b1;
            end
`endif
            default: state_d = StFetch;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .op_b5_i       (op[5]),
        .funct7b5_i    (funct7b5),
        .alu_control_o (alu_control)
    );

    // While reset is held every control is forced quiet, even though the
    // state register already reads FETCH.
    assign PCWrite    = reset ? 1'b0 : pc_write;
    assign AdrSrc     = reset ? 1'b0 : adr_src;
    assign MemWrite   = reset ? 1'b0 : mem_write;
    assign IRWrite    = reset ? 1'b0 : ir_write;
    assign RegWrite   = reset ? 1'b0 : reg_write;
    assign ResultSrc  = reset ? 2'b00 : result_src;
    assign ALUSrcA    = reset ? 2'b00 : alu_src_a;
    assign ALUSrcB    = reset ? 2'b00 : alu_src_b;
    assign ALUControl = reset ? 3'b000 : alu_control;
    assign ImmSrc     = reset ? 2'b00 : imm_src(op);
    assign state_o    = state_q;
`ifdef CTRL_ILLEGAL_HALT_EN
    assign halted     = reset ? 1'b0 : halt_flag;
`else
    assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm. An instruction-level model
// expands each instruction into its expected per-cycle control sequence.
module tb_multicycle_control_fsm;
    import riscv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, halted;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;
    logic [16:0] obs;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .halted     (halted),
        .state_o    (state_o)
    );

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUControl, ImmSrc, RegWrite, halted};

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic       pcw, adr, mw, irw;
        logic [1:0] rs, sa, sb;
        logic [2:0] alu;
        logic       rw;
    } step_t;

    step_t q[$];

    function automatic step_t mk(input logic [3:0] st, input logic rdy, input logic pcw,
                                 input logic adr, input logic mw, input logic irw,
                                 input logic [1:0] rs, input logic [1:0] sa,
                                 input logic [1:0] sb, input logic [2:0] alu,
                                 input logic rw);
        step_t s;
        s.st = st; s.rdy = rdy; s.pcw = pcw; s.adr = adr; s.mw = mw; s.irw = irw;
        s.rs = rs; s.sa = sa; s.sb = sb; s.alu = alu; s.rw = rw;
        return s;
    endfunction

    function automatic logic [1:0] imm_ref(input logic [6:0] o);
        if (o == 7'b0100011)      return 2'b01;
        else if (o == 7'b1100011) return 2'b10;
        else if (o == 7'b1101111) return 2'b11;
        else                      return 2'b00;
    endfunction

    function automatic logic [2:0] alu_ref(input logic is_r, input logic [2:0] f3,
                                           input logic f7);
        case (f3)
            3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its expected cycle sequence.
    // nf = fetch stall cycles, nm = data-memory stall cycles.
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input int nf, input int nm);
        q.delete();
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        for (int i = 0; i < nf; i++)
            q.push_back(mk(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));
        q.push_back(mk(4'd0, 1, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0));
        q.push_back(mk(4'd1, rbit(), 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0));
        if (o == 7'b0000011) begin
            q.push_back(mk(4'd2, rbit(), 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0));
            for (int i = 0; i < nm; i++)
                q.push_back(mk(4'd3, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0));
            q.push_back(mk(4'd3, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0));
            q.push_back(mk(4'd4, rbit(), 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1));
        end else if (o == 7'b0100011) begin
            q.push_back(mk(4'd2, rbit(), 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0));
            for (int i = 0; i < nm; i++)
                q.push_back(mk(4'd5, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0));
            q.push_back(mk(4'd5, 1, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        end else if (o == 7'b0110011 || o == 7'b0010011) begin
            q.push_back(mk((o == 7'b0110011) ? 4'd6 : 4'd7, rbit(), 0, 0, 0, 0, 2'b00,
                           2'b10, (o == 7'b0110011) ? 2'b00 : 2'b01,
                           alu_ref(o[5], f3, f7), 0));
            q.push_back(mk(4'd8, rbit(), 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1));
        end else if (o == 7'b1100011) begin
            q.push_back(mk(4'd9, rbit(), z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0));
        end else if (o == 7'b1101111) begin
            q.push_back(mk(4'd10, rbit(), 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0));
            q.push_back(mk(4'd8, rbit(), 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1));
        end
    endtask

    task automatic check(input string tag, input logic [3:0] st, input logic [16:0] ev);
        n_vec++;
        assert (state_o === st) else begin
            n_err++;
            $error("FAIL %s state: got %0d expected %0d", tag, state_o, st);
        end
        n_vec++;
        assert (obs === ev) else begin
            n_err++;
            $error("FAIL %s outputs: got %b expected %b", tag, obs, ev);
        end
    endtask

    // Drive and check up to 'limit' steps; enter and leave at posedge + 1.
    task automatic apply(input string name, input int limit);
        for (int i = 0; i < q.size() && i < limit; i++) begin
            mem_ready = q[i].rdy;
            #1;
            check($sformatf("%s[%0d]", name, i), q[i].st,
                  {q[i].pcw, q[i].adr, q[i].mw, q[i].irw, q[i].rs, q[i].sa, q[i].sb,
                   q[i].alu, imm_ref(op), q[i].rw, 1'b0});
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] ops [6];
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;

        reset = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; Zero = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("reset-async", 4'd0, 17'd0);
        @(posedge clk);
        #1;
        check("reset-held", 4'd0, 17'd0);
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        build(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0); apply("lw", 100);
        build(7'b0100011, 3'b010, 1'b0, 1'b0, 1, 3); apply("sw-stall", 100);
        build(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0); apply("beq-taken", 100);
        build(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0); apply("beq-not", 100);
        build(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0); apply("sub", 100);
        build(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0); apply("addi", 100);
        build(7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0); apply("slt", 100);
        build(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0); apply("jal", 100);

        // Reset arriving mid-MEMREAD while memory is stalled.
        build(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 5); apply("lw-abort", 4);
        mem_ready = 1'b0;
        #2;
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("abort-async", 4'd0, 17'd0);
        @(posedge clk);
        #1;
        check("abort-held", 4'd0, 17'd0);
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 40; n++) begin
            build(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), rbit(), rbit(),
                  $urandom_range(0, 2), $urandom_range(0, 3));
            apply($sformatf("rnd%0d", n), 100);
        end

        // Unknown opcode.
        build(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0); apply("illegal", 100);
`ifdef CTRL_ILLEGAL_HALT_EN
        for (int i = 0; i < 100; i++) begin
            mem_ready = rbit();
            #1;
            check("halt", 4'd11, 17'd1);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        check("halt-reset", 4'd0, 17'd0);
        @(negedge clk);
        reset = 1'b0;
`else
        mem_ready = 1'b0;
        #1;
        check("illegal-next", 4'd0, {4'b0000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0});
`endif
        @(posedge clk);
        #1;
        build(7'b0010011, 3'b111, 1'b0, 1'b0, 0, 0); apply("andi", 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
